// File: rtl/fp_norm_share_arb.sv
// fp_norm_share_arb: round-robin arbiter feeding one shared leading-zero
// detector and left shifter. Stage A captures the granted lane's operands,
// stage B registers the normalised result tagged with the requester ID.
module fp_norm_share_arb #(
    parameter int NREQ = 4,
    parameter int DW   = 16,
    parameter int EW   = 8,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_vld,
    output logic [NREQ-1:0]      req_rdy,
    input  logic [NREQ*DW-1:0]   req_mant,
    input  logic [NREQ*EW-1:0]   req_exp,
    output logic                 rsp_vld,
    input  logic                 rsp_rdy,
    output logic [IDW-1:0]       rsp_id,
    output logic [DW-1:0]        rsp_mant,
    output logic [EW-1:0]        rsp_exp,
    output logic                 rsp_zero,
    output logic                 rsp_uflow
);

    localparam int LZW = $clog2(DW-1);

    // Flat lane buses reinterpreted as packed per-lane arrays (lane i at [i*W +: W]).
    logic [NREQ-1:0][DW-1:0] lane_mant;
    logic [NREQ-1:0][EW-1:0] lane_exp;
    assign lane_mant = req_mant;
    assign lane_exp  = req_exp;

    // vld_pipe[0] = stage A valid, vld_pipe[1] = stage B valid.
    logic [1:0]      vld_pipe;
    logic            adv_a, adv_b;
    logic [IDW-1:0]  ptr, ptr_nxt, gnt_id;
    logic [NREQ-1:0] grant;
    logic [IDW:0]    cand;

    logic [IDW-1:0]  a_id;
    logic [DW-1:0]   a_mant;
    logic [EW-1:0]   a_exp;

    logic [LZW-1:0]  lz;
    logic            hit;
    logic [DW-1:0]   n_mant;
    logic [EW-1:0]   n_exp;
    logic            n_zero, n_uflow;

    assign adv_b   = ~vld_pipe[1] | rsp_rdy;
    assign adv_a   = ~vld_pipe[0] | adv_b;
    assign req_rdy = grant;
    assign rsp_vld = vld_pipe[1];
    assign ptr_nxt = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + IDW'(1);

    // Rotating priority search starting at ptr; gated by reset so ready drops
    // the instant rst_n falls, even though it is combinational.
    always_comb begin
        grant  = '0;
        gnt_id = '0;
        cand   = '0;
        if (rst_n && adv_a) begin
            for (int k = 0; k < NREQ; k++) begin
                cand = {1'b0, ptr} + (IDW+1)'(k);
                if (cand >= (IDW+1)'(NREQ))
                    cand = cand - (IDW+1)'(NREQ);
                if (grant == '0 && req_vld[cand[IDW-1:0]]) begin
                    grant[cand[IDW-1:0]] = 1'b1;
                    gnt_id               = cand[IDW-1:0];
                end
            end
        end
    end

    // Pointer moves past the lane that just transferred; holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (|grant)
            ptr <= ptr_nxt;
    end

    // Stage A: capture the granted operand; empties when nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe[0] <= 1'b0;
            a_id        <= '0;
            a_mant      <= '0;
            a_exp       <= '0;
        end else if (adv_a) begin
            vld_pipe[0] <= |grant;
            if (|grant) begin
                a_id   <= gnt_id;
                a_mant <= lane_mant[gnt_id];
                a_exp  <= lane_exp[gnt_id];
            end
        end
    end

    // Leading-zero count of the stage A mantissa (MSB-first priority search).
    always_comb begin
        lz  = '0;
        hit = 1'b0;
        for (int i = DW-1; i >= 0; i--) begin
            if (!hit && a_mant[i]) begin
                hit = 1'b1;
                lz  = LZW'(DW-1-i);
            end
        end
    end

    // Normalise; when the exponent cannot absorb the full shift, shift only
    // by the exponent and flag underflow so the pack stage can denormalise.
    always_comb begin
        n_mant  = '0;
        n_exp   = '0;
        n_zero  = 1'b0;
        n_uflow = 1'b0;
        if (a_mant == '0) begin
            n_zero = 1'b1;
        end else if (32'(a_exp) >= 32'(lz)) begin
            n_mant = a_mant << lz;
            n_exp  = a_exp - EW'(lz);
        end else begin
            n_mant  = a_mant << a_exp;
            n_uflow = 1'b1;
        end
    end

    // Stage B: output register; holds all rsp_* while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe[1] <= 1'b0;
            rsp_id      <= '0;
            rsp_mant    <= '0;
            rsp_exp     <= '0;
            rsp_zero    <= 1'b0;
            rsp_uflow   <= 1'b0;
        end else if (adv_b) begin
            vld_pipe[1] <= vld_pipe[0];
            if (vld_pipe[0]) begin
                rsp_id    <= a_id;
                rsp_mant  <= n_mant;
                rsp_exp   <= n_exp;
                rsp_zero  <= n_zero;
                rsp_uflow <= n_uflow;
            end
        end
    end

endmodule

// File: tb/tb_fp_norm_share_arb.sv
// Bench for fp_norm_share_arb: table of normalisation vectors, directed
// latency/fairness/backpressure/reset sequences, and a randomized run
// scored against a queue-based reference model.
module tb_fp_norm_share_arb;

    localparam int NREQ = 4;
    localparam int DW   = 16;
    localparam int EW   = 8;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req_vld, req_rdy;
    logic [NREQ*DW-1:0]  req_mant;
    logic [NREQ*EW-1:0]  req_exp;
    logic                rsp_vld, rsp_rdy;
    logic [IDW-1:0]      rsp_id;
    logic [DW-1:0]       rsp_mant;
    logic [EW-1:0]       rsp_exp;
    logic                rsp_zero, rsp_uflow;

    logic [DW-1:0] lm [NREQ];
    logic [EW-1:0] le [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign req_mant[g*DW +: DW] = lm[g];
        assign req_exp[g*EW +: EW]  = le[g];
    end

    fp_norm_share_arb #(.NREQ(NREQ), .DW(DW), .EW(EW), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_vld(req_vld), .req_rdy(req_rdy),
        .req_mant(req_mant), .req_exp(req_exp),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
        .rsp_id(rsp_id), .rsp_mant(rsp_mant), .rsp_exp(rsp_exp),
        .rsp_zero(rsp_zero), .rsp_uflow(rsp_uflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [DW-1:0]  mant;
        logic [EW-1:0]  exp;
        logic           zero;
        logic           uflow;
    } res_t;

    typedef struct {
        logic [DW-1:0] m;
        logic [EW-1:0] e;
        logic [DW-1:0] em;
        logic [EW-1:0] ee;
        logic          ez;
        logic          eu;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];
    int   out_log[$];
    int   mptr = 0, inflight = 0, n_acc = 0;
    logic stall_prev = 1'b0;
    res_t prev_rsp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference: count leading zeros arithmetically, then apply the exponent limit.
    function automatic res_t ref_norm(input logic [DW-1:0] m, input logic [EW-1:0] e, input int id);
        res_t r;
        int   lz;
        r = '0;
        r.id = IDW'(id);
        if (m == '0) begin
            r.zero = 1'b1;
        end else begin
            lz = 0;
            while (m[DW-1-lz] == 1'b0) lz++;
            if (int'(e) >= lz) begin
                r.mant = m << lz;
                r.exp  = e - EW'(lz);
            end else begin
                r.mant  = m << e;
                r.uflow = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic res_t cur_rsp();
        return {rsp_id, rsp_mant, rsp_exp, rsp_zero, rsp_uflow};
    endfunction

    task automatic model_clear();
        exp_q.delete();
        out_log.delete();
        mptr = 0; inflight = 0; n_acc = 0;
        stall_prev = 1'b0;
    endtask

    // One clock of checking: expected grant from model pointer and occupancy,
    // output hold while stalled, and in-order scoreboard on each response.
    task automatic step();
        logic [NREQ-1:0] eg;
        int              gi;
        res_t            got, e;
        eg = '0; gi = 0;
        @(negedge clk);
        if ((inflight < 2) || rsp_rdy) begin
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (mptr + k) % NREQ;
                if (eg == '0 && req_vld[idx]) begin
                    eg[idx] = 1'b1;
                    gi = idx;
                end
            end
        end
        chk("req_rdy", 32'(req_rdy), 32'(eg));
        got = cur_rsp();
        if (stall_prev) begin
            chk("rsp_vld_hold", 32'(rsp_vld), 32'd1);
            chk("rsp_hold", 32'(got), 32'(prev_rsp));
        end
        if (rsp_vld && rsp_rdy) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rsp_unexpected: got id %0d mant %0h, required none", rsp_id, rsp_mant);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_data", 32'(got), 32'(e));
                out_log.push_back(int'(rsp_id));
                inflight--;
            end
        end
        if (eg != '0) begin
            exp_q.push_back(ref_norm(lm[gi], le[gi], gi));
            mptr = (gi + 1) % NREQ;
            inflight++;
            n_acc++;
        end
        stall_prev = rsp_vld && !rsp_rdy;
        prev_rsp   = got;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        req_vld = '0; rsp_rdy = 1'b0; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        model_clear();
        @(posedge clk); #1;
    endtask

    function automatic logic [DW-1:0] rand_mant();
        logic [DW-1:0] r;
        r = DW'($urandom);
        if ($urandom_range(0, 5) == 0) return '0;
        return r >> $urandom_range(0, DW-1);
    endfunction

    vec_t vt[9];

    initial begin
        vt[0] = '{16'h0010, 8'd5,   16'h0200, 8'd0,   1'b0, 1'b1};
        vt[1] = '{16'h0000, 8'd77,  16'h0000, 8'd0,   1'b1, 1'b0};
        vt[2] = '{16'h8000, 8'd0,   16'h8000, 8'd0,   1'b0, 1'b0};
        vt[3] = '{16'h0001, 8'd15,  16'h8000, 8'd0,   1'b0, 1'b0};
        vt[4] = '{16'h0001, 8'd14,  16'h4000, 8'd0,   1'b0, 1'b1};
        vt[5] = '{16'h00FF, 8'd200, 16'hFF00, 8'd192, 1'b0, 1'b0};
        vt[6] = '{16'h0001, 8'd0,   16'h0001, 8'd0,   1'b0, 1'b1};
        vt[7] = '{16'h7FFF, 8'd255, 16'hFFFE, 8'd254, 1'b0, 1'b0};
        vt[8] = '{16'h0ABC, 8'd3,   16'h55E0, 8'd0,   1'b0, 1'b1};

        for (int i = 0; i < NREQ; i++) begin lm[i] = '0; le[i] = '0; end
        req_vld = '0; rsp_rdy = 1'b0;

        // Reset state, checked while rst_n is still low.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld", 32'(rsp_vld), 32'd0);
        chk("rst_rdy", 32'(req_rdy), 32'd0);
        chk("rst_rsp", 32'(cur_rsp()), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        model_clear();
        @(posedge clk); #1;

        // Single op on lane 2: two-edge latency.
        lm[2] = 16'h0123; le[2] = 8'd20; req_vld = 4'b0100; rsp_rdy = 1'b1;
        #1 chk("single_gnt", 32'(req_rdy), 32'h4);
        step();
        req_vld = '0;
        chk("single_lat1", 32'(rsp_vld), 32'd0);
        step();
        chk("single_out", {3'b0, rsp_vld, cur_rsp()}, {3'b0, 1'b1, 2'd2, 16'h9180, 8'd13, 1'b0, 1'b0});
        step();

        // Normalisation vectors, one at a time, rotating lanes.
        for (int i = 0; i < 9; i++) begin
            int lane;
            lane = i % NREQ;
            lm[lane] = vt[i].m; le[lane] = vt[i].e;
            req_vld = NREQ'(1) << lane;
            step();
            req_vld = '0;
            step();
            chk($sformatf("vec%0d", i), {3'b0, rsp_vld, cur_rsp()},
                {3'b0, 1'b1, IDW'(lane), vt[i].em, vt[i].ee, vt[i].ez, vt[i].eu});
            step();
        end

        // Fairness: all lanes requesting from ptr=0.
        do_reset();
        rsp_rdy = 1'b1; req_vld = '1;
        for (int k = 0; k < 8; k++) begin
            lm[k % NREQ] = rand_mant(); le[k % NREQ] = 8'($urandom_range(0, 255));
            #1 chk("fair_gnt", 32'(req_rdy), 32'(1) << (k % NREQ));
            step();
        end
        req_vld = '0;
        repeat (3) step();
        chk("fair_cnt", 32'(out_log.size()), 32'd8);
        for (int k = 0; k < 8 && k < out_log.size(); k++)
            chk("fair_order", 32'(out_log[k]), 32'(k % NREQ));

        // Backpressure on a lane-1 stream; mantissa encodes sequence number.
        do_reset();
        rsp_rdy = 1'b0; req_vld = 4'b0010; le[1] = 8'd30;
        for (int k = 0; k < 5; k++) begin
            lm[1] = 16'h0100 + 16'(n_acc);
            #1 if (k >= 2) chk("bp_rdy_low", 32'(req_rdy), 32'd0);
            step();
        end
        rsp_rdy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            lm[1] = 16'h0100 + 16'(n_acc);
            step();
        end
        req_vld = '0;
        repeat (3) step();
        chk("bp_drain", 32'(exp_q.size()), 32'd0);
        chk("bp_count", 32'(out_log.size()), 32'(n_acc));

        // Reset mid-flight with both stages full and ptr=3.
        do_reset();
        rsp_rdy = 1'b0; lm[2] = 16'h0F00; le[2] = 8'd9; req_vld = 4'b0100;
        step(); step();
        req_vld = '1; rsp_rdy = 1'b1;
        #1 chk("pre_rst_gnt", 32'(req_rdy), 32'h8);
        chk("pre_rst_vld", 32'(rsp_vld), 32'd1);
        rst_n = 1'b0;
        #1 chk("rst_async_vld", 32'(rsp_vld), 32'd0);
        chk("rst_async_rdy", 32'(req_rdy), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        model_clear();
        #1 chk("post_rst_gnt", 32'(req_rdy), 32'h1);
        step();
        req_vld = '0;
        repeat (3) step();
        chk("post_rst_drain", 32'(exp_q.size()), 32'd0);

        // Randomized traffic with random backpressure.
        do_reset();
        repeat (400) begin
            req_vld = NREQ'($urandom);
            rsp_rdy = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                lm[i] = rand_mant();
                le[i] = $urandom_range(0, 1) ? 8'($urandom_range(0, 20)) : 8'($urandom_range(0, 255));
            end
            step();
        end
        req_vld = '0; rsp_rdy = 1'b1;
        repeat (4) step();
        chk("rand_drain", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
